// File: rtl/katadc_config_arbiter.sv
// Arbiter sharing one serial-config engine between the autoconfig sequencer
// and software register writes. Autoconfig has priority; software waits for
// auto_busy to drop. Each transaction is issued once and then waits for
// cfg_done or a timeout.
module katadc_config_arbiter #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_busy,
  input  logic [15:0] auto_data,
  input  logic [3:0]  auto_addr,
  input  logic        auto_start,
  output logic        auto_done,
  input  logic [15:0] sw_data,
  input  logic [3:0]  sw_addr,
  input  logic        sw_start,
  output logic        sw_done,
  output logic        sw_pending,
  output logic        sw_drop,
  output logic [15:0] cfg_data,
  output logic [3:0]  cfg_addr,
  output logic        cfg_start,
  input  logic        cfg_done,
  output logic        owner,
  output logic        err_timeout,
  output logic [7:0]  timeout_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned TOC_W  = 8;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [TOC_W-1:0] TOC_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              auto_pend, auto_pend_nx;
  logic              sw_pend, sw_pend_nx;
  logic [DATA_W-1:0] sw_data_q, sw_data_nx;
  logic [ADDR_W-1:0] sw_addr_q, sw_addr_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;

  logic              owner_nx;
  logic [DATA_W-1:0] cfg_data_nx;
  logic [ADDR_W-1:0] cfg_addr_nx;
  logic              cfg_start_nx;
  logic              auto_done_nx;
  logic              sw_done_nx;
  logic              sw_drop_nx;
  logic              err_timeout_nx;
  logic [TOC_W-1:0]  timeout_count_nx;
  logic              sw_pending_nx;

  logic grant_auto, grant_sw;
  logic done_hit, tmo_hit, finish;
  logic auto_clr, sw_clr, sw_accept;

  // Transaction events shared by the next-state and output logic
  always_comb begin
    grant_auto = (state == S_IDLE) && auto_pend;
    grant_sw   = (state == S_IDLE) && !auto_pend && sw_pend && !auto_busy;
    done_hit   = (state == S_WAIT) && cfg_done;
    tmo_hit    = (state == S_WAIT) && !cfg_done && (wait_cnt == WAIT_LAST);
    finish     = done_hit || tmo_hit;
    auto_clr   = finish && !owner;
    sw_clr     = finish && owner;
    sw_accept  = sw_start && (!sw_pend || sw_clr);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_auto || grant_sw) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (finish) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and bookkeeping registers
  always_comb begin
    owner_nx         = owner;
    auto_pend_nx     = auto_pend;
    sw_pend_nx       = sw_pend;
    sw_data_nx       = sw_data_q;
    sw_addr_nx       = sw_addr_q;
    wait_cnt_nx      = '0;
    cfg_data_nx      = cfg_data;
    cfg_addr_nx      = cfg_addr;
    cfg_start_nx     = 1'b0;
    auto_done_nx     = auto_clr;
    sw_done_nx       = sw_clr;
    sw_drop_nx       = sw_start && sw_pend && !sw_clr;
    err_timeout_nx   = tmo_hit;
    timeout_count_nx = timeout_count;

    if (grant_auto)    owner_nx = 1'b0;
    else if (grant_sw) owner_nx = 1'b1;

    // A new pulse always wins over a completion clearing the flag
    if (auto_start)    auto_pend_nx = 1'b1;
    else if (auto_clr) auto_pend_nx = 1'b0;

    if (sw_accept) begin
      sw_pend_nx = 1'b1;
      sw_data_nx = sw_data;
      sw_addr_nx = sw_addr;
    end else if (sw_clr) begin
      sw_pend_nx = 1'b0;
    end

    if (state == S_ISSUE) begin
      cfg_start_nx = 1'b1;
      cfg_data_nx  = owner ? sw_data_q : auto_data;
      cfg_addr_nx  = owner ? sw_addr_q : auto_addr;
    end

    if ((state == S_WAIT) && !finish) wait_cnt_nx = wait_cnt + CNT_W'(1);

    if (tmo_hit && (timeout_count != TOC_MAX))
      timeout_count_nx = timeout_count + TOC_W'(1);

    sw_pending_nx = sw_pend_nx || (owner_nx && (state_nx != S_IDLE));
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_pend     <= 1'b0;
      sw_pend       <= 1'b0;
      sw_data_q     <= '0;
      sw_addr_q     <= '0;
      wait_cnt      <= '0;
      owner         <= 1'b0;
      cfg_data      <= '0;
      cfg_addr      <= '0;
      cfg_start     <= 1'b0;
      auto_done     <= 1'b0;
      sw_done       <= 1'b0;
      sw_drop       <= 1'b0;
      err_timeout   <= 1'b0;
      timeout_count <= '0;
      sw_pending    <= 1'b0;
    end else begin
      auto_pend     <= auto_pend_nx;
      sw_pend       <= sw_pend_nx;
      sw_data_q     <= sw_data_nx;
      sw_addr_q     <= sw_addr_nx;
      wait_cnt      <= wait_cnt_nx;
      owner         <= owner_nx;
      cfg_data      <= cfg_data_nx;
      cfg_addr      <= cfg_addr_nx;
      cfg_start     <= cfg_start_nx;
      auto_done     <= auto_done_nx;
      sw_done       <= sw_done_nx;
      sw_drop       <= sw_drop_nx;
      err_timeout   <= err_timeout_nx;
      timeout_count <= timeout_count_nx;
      sw_pending    <= sw_pending_nx;
    end
  end

endmodule
